mvm_result_streamer: RTL and testbench
======================================

# mvm_result_streamer

Output-side companion to the matrix-vector multiplier. It captures the wide parallel result vector in one cycle and streams it out one element per valid/ready handshake. Each element is scaled and narrowed from accumulator width to output width before it leaves the block. It sits between the MVM datapath and the next layer or output FIFO.

## Interface
- ROWS, 6, number of result elements (≥1)
- ACC_WIDTH, 16, width of each accumulator element in result_vector (signed two's complement)
- OUT_WIDTH, 8, width of each streamed element (OUT_WIDTH ≤ ACC_WIDTH)
- SHIFT, 0, arithmetic right shift applied before narrowing (0 ≤ SHIFT < ACC_WIDTH)
- IDX_W (localparam), max(1, clog2(ROWS)), width of out_index

- clk  input  1  sole clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- load  input  1  capture request for result_vector
- result_vector  input  ROWS*ACC_WIDTH  element k occupies bits [k*ACC_WIDTH +: ACC_WIDTH]
- busy  output  1  high while a captured vector is not fully sent
- overrun  output  1  one-cycle pulse when a load is dropped
- out_data  output  OUT_WIDTH  current narrowed element
- out_valid  output  1  out_data/out_index/out_last are valid
- out_ready  input  1  downstream accepts when high with out_valid
- out_last  output  1  high with the element at index ROWS-1
- out_index  output  IDX_W  index of the current element

## Operation
- States:
  - IDLE: busy=0, out_valid=0.
  - SEND: busy=1, out_valid=1.
- IDLE + load: register all of result_vector into an internal buffer, set idx=0, go to SEND.
- SEND: a handshake (out_valid & out_ready) advances idx.
  - Handshake at idx=ROWS-1 without load: go to IDLE.
  - Handshake at idx=ROWS-1 with load in the same cycle: recapture, set idx=0, stay in SEND (back-to-back, no bubble).
- load in SEND, other than on the final handshake: dropped, buffer unchanged, overrun pulses high for the next cycle.
- out_index = idx. out_last = (idx == ROWS-1) while in SEND. ROWS=1: every element is last.
- Narrowing: s = buf[idx] >>> SHIFT, sign-extended. out_data = narrow(s) per Configuration.
- The buffer is the only copy of the data. Changes on result_vector after capture do not affect output.
- out_data and out_index hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset (synchronous), next edge:
  - state=IDLE, idx=0, buffer cleared.
  - busy=0, out_valid=0, out_last=0, overrun=0, out_data=0, out_index=0.
- load sampled at edge N: out_valid=1 with element 0 from N+1. Latency is 1 cycle.
- With out_ready held high, one element per cycle. ROWS elements occupy cycles N+1 .. N+ROWS; busy falls at N+ROWS+1.
- Outputs are registered, with no combinational path from out_ready to out_data/out_valid. out_data is registered from buffer plus idx at each advance.
- reset mid-stream: the stream is abandoned with no further valid beats. A load in the same cycle as reset is ignored.
- out_ready may be high while out_valid=0. This has no effect.

## Configuration
- MVM_STREAM_SAT_EN defined: narrow(s) saturates to the signed range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- MVM_STREAM_SAT_EN undefined: narrow(s) = s[OUT_WIDTH-1:0] (plain truncation, wraps).
- Interface and timing are identical in both builds.

## Test plan
All scenarios use ROWS=4, ACC_WIDTH=16, OUT_WIDTH=8, SHIFT=0. Vector = {0x007F, 0xFF00, 0x0190, 0x0005} (element 3..0).
- Load once, out_ready=1 constantly:
  - SAT build: out_data 0x05, 0x7F, 0x80, 0x7F on 4 consecutive cycles; out_index 0..3; out_last only on the 4th; busy low after.
- Same stimulus, no-SAT build: out_data 0x05, 0x90, 0x00, 0x7F.
- out_ready toggled 1,0,0,1,... : out_data and out_index hold across stalled cycles, and exactly 4 beats are transferred.
- Second load mid-stream (idx=1): overrun pulses 1 cycle and the stream completes with the original data. Second load on the final handshake: next cycle out_valid=1, out_index=0, new data, no bubble.
- reset asserted at idx=2: next cycle out_valid=0 and busy=0. A following load restarts at index 0.
- SHIFT=4 (SAT build), element 0x0190: out_data=0x19.

Source files
------------

// File: rtl/mvm_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_result_streamer
//  Description : Output-side companion to the matrix-vector multiplier.
//                Captures the wide parallel result vector in one cycle and
//                streams it out one element per valid/ready handshake. Each
//                element is arithmetically right-shifted by SHIFT and then
//                narrowed from ACC_WIDTH to OUT_WIDTH bits.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro:
//    MVM_STREAM_SAT_EN  defined   -> narrowing saturates to the signed
//                                    OUT_WIDTH range
//                       undefined -> narrowing truncates (wraps)
// ----------------------------------------------------------------------------
//  Ports:
//    clk            in   1               rising-edge clock
//    reset          in   1               synchronous, active-high
//    load           in   1               capture request for result_vector
//    result_vector  in   ROWS*ACC_WIDTH  element k at [k*ACC_WIDTH +: ACC_WIDTH]
//    busy           out  1               captured vector not yet fully sent
//    overrun        out  1               one-cycle pulse when a load is dropped
//    out_data       out  OUT_WIDTH       current narrowed element
//    out_valid      out  1               out_data/out_index/out_last valid
//    out_ready      in   1               downstream accepts when high
//    out_last       out  1               current element is index ROWS-1
//    out_index      out  IDX_W           index of the current element
// ============================================================================
module mvm_result_streamer #(
    parameter int ROWS      = 6,
    parameter int ACC_WIDTH = 16,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 0,
    localparam int IDX_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [ROWS*ACC_WIDTH-1:0] result_vector,
    output logic                      busy,
    output logic                      overrun,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [IDX_W-1:0]          out_index
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [IDX_W-1:0] c_LAST_IDX      = IDX_W'(ROWS - 1);
    localparam logic             c_FIRST_IS_LAST = (ROWS == 1);

`ifdef MVM_STREAM_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] c_SAT_MAX =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_SAT_MIN =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
`endif

    // Shift then narrow one accumulator element.
    function automatic logic [OUT_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] s;
        s = a >>> SHIFT;
`ifdef MVM_STREAM_SAT_EN
        if (s > c_SAT_MAX) begin
            narrow = c_SAT_MAX[OUT_WIDTH-1:0];
        end else if (s < c_SAT_MIN) begin
            narrow = c_SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            narrow = s[OUT_WIDTH-1:0];
        end
`else
        narrow = s[OUT_WIDTH-1:0];
`endif
    endfunction

    logic [0:0]                r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [ROWS*ACC_WIDTH-1:0] r_buf;
    logic                      r_overrun;
    logic [OUT_WIDTH-1:0]      r_out_data;
    logic                      r_out_last;

    logic                      w_handshake;
    logic                      w_at_last;
    logic [IDX_W-1:0]          w_idx_next;
    logic [ACC_WIDTH-1:0]      w_next_elem;

    assign w_handshake = (r_state == S_SEND) && out_ready;
    assign w_at_last   = (r_idx == c_LAST_IDX);
    assign w_idx_next  = r_idx + IDX_W'(1);

    // Element that becomes current on a non-final advance. out_data is
    // registered from this so out_ready never reaches out_data combinationally.
    always_comb begin
        w_next_elem = '0;
        for (int k = 0; k < ROWS; k++) begin
            if (w_idx_next == IDX_W'(k)) begin
                w_next_elem = r_buf[k*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_buf      <= '0;
            r_overrun  <= 1'b0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_buf      <= result_vector;
                        r_idx      <= '0;
                        r_out_data <= narrow(result_vector[ACC_WIDTH-1:0]);
                        r_out_last <= c_FIRST_IS_LAST;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_handshake && w_at_last) begin
                        if (load) begin
                            // Back-to-back: recapture on the final beat, no bubble.
                            r_buf      <= result_vector;
                            r_idx      <= '0;
                            r_out_data <= narrow(result_vector[ACC_WIDTH-1:0]);
                            r_out_last <= c_FIRST_IS_LAST;
                        end else begin
                            r_idx      <= '0;
                            r_out_last <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end else begin
                        if (w_handshake) begin
                            r_idx      <= w_idx_next;
                            r_out_data <= narrow(w_next_elem);
                            r_out_last <= (w_idx_next == c_LAST_IDX);
                        end
                        // Any load not coinciding with the final beat is lost.
                        if (load) begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == S_SEND);
    assign out_valid = (r_state == S_SEND);
    assign out_last  = r_out_last;
    assign out_index = r_idx;
    assign out_data  = r_out_data;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mvm_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvm_result_streamer
//  Description : Directed self-checking bench for mvm_result_streamer with
//                ROWS=4, ACC_WIDTH=16, OUT_WIDTH=8. A second instance with
//                SHIFT=4 runs on the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mvm_result_streamer;

    localparam int ROWS = 4;
    localparam int ACC_WIDTH = 16;
    localparam int OUT_WIDTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [63:0] result_vector;
    logic        out_ready;

    logic        busy, overrun, out_valid, out_last;
    logic [7:0]  out_data;
    logic [1:0]  out_index;

    logic        d2_busy, d2_overrun, d2_out_valid, d2_out_last;
    logic [7:0]  d2_out_data;
    logic [1:0]  d2_out_index;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] vec_a = {16'h007F, 16'hFF00, 16'h0190, 16'h0005};
    logic [63:0] vec_b = {16'h0004, 16'h0003, 16'h0012, 16'h0041};
    logic [7:0]  exp_a [4];
    logic [7:0]  exp_s [4];
    logic [7:0]  exp_b [4];

    always #5 clk = ~clk;

    mvm_result_streamer #(
        .ROWS(ROWS), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(0)
    ) dut (
        .clk(clk), .reset(reset), .load(load), .result_vector(result_vector),
        .busy(busy), .overrun(overrun), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_index(out_index)
    );

    mvm_result_streamer #(
        .ROWS(ROWS), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .SHIFT(4)
    ) dut_shift (
        .clk(clk), .reset(reset), .load(load), .result_vector(result_vector),
        .busy(d2_busy), .overrun(d2_overrun), .out_data(d2_out_data),
        .out_valid(d2_out_valid), .out_ready(out_ready), .out_last(d2_out_last),
        .out_index(d2_out_index)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let the current stream finish; a stream that never ends is a failure.
    task automatic drain(input string name);
        for (int c = 0; c < 20 && out_valid; c++) tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL %s_drain: out_valid=%b required 0", name, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; result_vector = vec_a; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0; load = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_last !== 1'b0) $display("FAIL rst_last: got %b required 0", out_last); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b required 0", overrun); else pass_cnt++;
        total_cnt++; if (out_data !== 8'h00) $display("FAIL rst_data: got %h required 00", out_data); else pass_cnt++;
        total_cnt++; if (out_index !== 2'd0) $display("FAIL rst_index: got %0d required 0", out_index); else pass_cnt++;
        // out_ready high while idle must not start anything
        tick(); tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL idle_ready_valid: got %b required 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_stream();
        out_ready = 1'b1; load = 1'b1; result_vector = vec_a;
        tick();
        load = 1'b0; result_vector = '0;  // capture buffer must be the only copy
        for (int b = 0; b < 4; b++) begin
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL stream_valid%0d: got %b required 1", b, out_valid); else pass_cnt++;
            total_cnt++; if (out_data !== exp_a[b]) $display("FAIL stream_data%0d: got %h required %h", b, out_data, exp_a[b]); else pass_cnt++;
            total_cnt++; if (out_index !== 2'(b)) $display("FAIL stream_index%0d: got %0d required %0d", b, out_index, b); else pass_cnt++;
            total_cnt++; if (out_last !== (b == 3)) $display("FAIL stream_last%0d: got %b required %b", b, out_last, (b == 3)); else pass_cnt++;
            total_cnt++; if (d2_out_data !== exp_s[b]) $display("FAIL shift4_data%0d: got %h required %h", b, d2_out_data, exp_s[b]); else pass_cnt++;
            tick();
        end
        total_cnt++; if (busy !== 1'b0) $display("FAIL stream_busy_end: got %b required 0", busy); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_valid_end: got %b required 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_stall();
        int         beats;
        logic       held;
        logic [7:0] hd;
        logic [1:0] hi;
        beats = 0; held = 1'b0; hd = '0; hi = '0;
        out_ready = 1'b0; load = 1'b1; result_vector = vec_a;
        tick();
        load = 1'b0;
        for (int c = 0; c < 40 && out_valid; c++) begin
            if (held) begin
                total_cnt++; if (out_data !== hd) $display("FAIL stall_hold_data: got %h required %h", out_data, hd); else pass_cnt++;
                total_cnt++; if (out_index !== hi) $display("FAIL stall_hold_index: got %0d required %0d", out_index, hi); else pass_cnt++;
            end
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (out_ready) begin
                if (beats < 4) begin
                    total_cnt++; if (out_data !== exp_a[beats]) $display("FAIL stall_data%0d: got %h required %h", beats, out_data, exp_a[beats]); else pass_cnt++;
                    total_cnt++; if (out_index !== 2'(beats)) $display("FAIL stall_index%0d: got %0d required %0d", beats, out_index, beats); else pass_cnt++;
                end
                beats++;
                held = 1'b0;
            end else begin
                hd = out_data; hi = out_index; held = 1'b1;
            end
            tick();
        end
        out_ready = 1'b1;
        total_cnt++; if (beats !== 4) $display("FAIL stall_beats: got %0d required 4", beats); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_end_valid: got %b required 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_overrun();
        out_ready = 1'b1; load = 1'b1; result_vector = vec_a;
        tick();
        load = 1'b0;
        tick();                                 // index 1 now shown
        load = 1'b1; result_vector = vec_b;     // dropped load
        tick();
        load = 1'b0;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_pulse: got %b required 1", overrun); else pass_cnt++;
        total_cnt++; if (out_index !== 2'd2) $display("FAIL ovr_index2: got %0d required 2", out_index); else pass_cnt++;
        total_cnt++; if (out_data !== exp_a[2]) $display("FAIL ovr_data2: got %h required %h", out_data, exp_a[2]); else pass_cnt++;
        tick();
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b required 0", overrun); else pass_cnt++;
        total_cnt++; if (out_data !== exp_a[3]) $display("FAIL ovr_data3: got %h required %h", out_data, exp_a[3]); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL ovr_end_valid: got %b required 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; load = 1'b1; result_vector = vec_a;
        tick();
        load = 1'b0;
        tick(); tick(); tick();                 // index 3 now shown
        load = 1'b1; result_vector = vec_b;     // load on the final handshake
        tick();
        load = 1'b0;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid: got %b required 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_index !== 2'd0) $display("FAIL b2b_index: got %0d required 0", out_index); else pass_cnt++;
        total_cnt++; if (out_data !== exp_b[0]) $display("FAIL b2b_data0: got %h required %h", out_data, exp_b[0]); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b required 0", overrun); else pass_cnt++;
        tick();
        total_cnt++; if (out_data !== exp_b[1]) $display("FAIL b2b_data1: got %h required %h", out_data, exp_b[1]); else pass_cnt++;
        drain("b2b");
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1; load = 1'b1; result_vector = vec_a;
        tick();
        load = 1'b0;
        tick(); tick();                         // index 2 now shown
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mrst_valid: got %b required 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mrst_busy: got %b required 0", busy); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mrst_stay_idle: got %b required 0", out_valid); else pass_cnt++;
        load = 1'b1; result_vector = vec_a;
        tick();
        load = 1'b0;
        total_cnt++; if (out_index !== 2'd0) $display("FAIL mrst_restart_index: got %0d required 0", out_index); else pass_cnt++;
        total_cnt++; if (out_data !== exp_a[0]) $display("FAIL mrst_restart_data: got %h required %h", out_data, exp_a[0]); else pass_cnt++;
        drain("mrst");
    endtask

    initial begin
`ifdef MVM_STREAM_SAT_EN
        exp_a[0] = 8'h05; exp_a[1] = 8'h7F; exp_a[2] = 8'h80; exp_a[3] = 8'h7F;
`else
        exp_a[0] = 8'h05; exp_a[1] = 8'h90; exp_a[2] = 8'h00; exp_a[3] = 8'h7F;
`endif
        // SHIFT=4 results are in range, identical in both builds.
        exp_s[0] = 8'h00; exp_s[1] = 8'h19; exp_s[2] = 8'hF0; exp_s[3] = 8'h07;
        exp_b[0] = 8'h41; exp_b[1] = 8'h12; exp_b[2] = 8'h03; exp_b[3] = 8'h04;

        reset = 1'b1; load = 1'b0; result_vector = '0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_midstream();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
